// File: rtl/game_pkg.sv
// Shared types and constants for the air-hockey ball datapath.
package game_pkg;

  localparam int FIELD_W   = 100;
  localparam int FIELD_H   = 100;
  localparam int BALL_SIZE = 4;
  localparam int COORD_W   = 11;
  localparam int SCORE_W   = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX   = 4'd9;
  localparam logic [2:0]         BG_COLOUR   = 3'b000;
  localparam logic [2:0]         BALL_COLOUR = 3'b111;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_COLL,
    ST_SETTLE,
    ST_MOVE,
    ST_DRAW
  } seq_state_t;

  // One-pixel step clamped to [0, max_v]; inc selects the direction.
  function automatic coord_t step_sat(input coord_t v, input logic inc, input coord_t max_v);
    coord_t r;
    if (inc) r = (v >= max_v) ? max_v : v + coord_t'(1);
    else     r = (v == '0)    ? '0    : v - coord_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/box_pixel_walker.sv
// Walks the 16 pixels of a 4x4 box in raster order over a valid/ready
// handshake. A start pulse latches origin and colour and presents the first
// pixel on the next cycle; done pulses when the last pixel is accepted.
module box_pixel_walker
  import game_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [2:0]         colour,
  input  logic               plot_ready,
  output logic [COORD_W-1:0] plot_x,
  output logic [COORD_W-1:0] plot_y,
  output logic [2:0]         plot_colour,
  output logic               plot_valid,
  output logic               done
);

  logic [3:0] cnt;
  logic [3:0] cnt_next;
  coord_t     base_x;
  coord_t     base_y;
  logic       accept;

  assign accept   = plot_valid && plot_ready;
  assign done     = accept && (cnt == 4'd15);
  assign cnt_next = cnt + 4'd1;

  // Pixel request register: load on start, advance one offset per acceptance.
  // NOTE: clocked state uses non-blocking assignments so every register in the
  // block samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt         <= '0;
      base_x      <= '0;
      base_y      <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot_valid  <= 1'b0;
    end else if (start) begin
      cnt         <= '0;
      base_x      <= origin_x;
      base_y      <= origin_y;
      plot_x      <= origin_x;
      plot_y      <= origin_y;
      plot_colour <= colour;
      plot_valid  <= 1'b1;
    end else if (accept) begin
      if (cnt == 4'd15) begin
        cnt        <= '0;
        plot_valid <= 1'b0;
      end else begin
        cnt    <= cnt_next;
        plot_x <= base_x + coord_t'(cnt_next[1:0]);
        plot_y <= base_y + coord_t'(cnt_next[3:2]);
      end
    end
  end

endmodule

// File: rtl/ball_sequencer.sv
// Per-frame ball controller: erase, collision strobe, move with saturation,
// goal scoring, redraw. Owns the ball position and both score counters.
module ball_sequencer
  import game_pkg::*;
#(
  parameter int FIELD_W = game_pkg::FIELD_W,
  parameter int FIELD_H = game_pkg::FIELD_H,
  parameter int X_INIT  = 48,
  parameter int Y_INIT  = 48,
  parameter int GOAL_Y0 = 30,
  parameter int GOAL_Y1 = 66
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               horizontal,
  input  logic               vertical,
  output logic               coll_enable,
  output logic [COORD_W-1:0] x_ball,
  output logic [COORD_W-1:0] y_ball,
  output logic [COORD_W-1:0] plot_x,
  output logic [COORD_W-1:0] plot_y,
  output logic [2:0]         plot_colour,
  output logic               plot_valid,
  input  logic               plot_ready,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               busy
);

  localparam coord_t X_MAX   = coord_t'(FIELD_W - BALL_SIZE);
  localparam coord_t Y_MAX   = coord_t'(FIELD_H - BALL_SIZE);
  localparam coord_t X_START = coord_t'(X_INIT);
  localparam coord_t Y_START = coord_t'(Y_INIT);
  localparam coord_t GOAL_LO = coord_t'(GOAL_Y0);
  localparam coord_t GOAL_HI = coord_t'(GOAL_Y1);

  seq_state_t state;
  seq_state_t next_state;
  logic       pending;
  logic       skip_erase;
  logic       walk_start;
  logic [2:0] walk_colour;
  logic       walk_done;
  coord_t     x_step;
  coord_t     y_step;
  logic       in_mouth;
  logic       goal_left;
  logic       goal_right;

  // Candidate position for the MOVE update; vertical = 1 means move up (-y).
  assign x_step     = step_sat(x_ball, horizontal, X_MAX);
  assign y_step     = step_sat(y_ball, !vertical, Y_MAX);
  assign in_mouth   = (y_step >= GOAL_LO) && (y_step <= GOAL_HI);
  assign goal_left  = in_mouth && (x_step == '0);
  assign goal_right = in_mouth && (x_step == X_MAX);

  // State register.
  // NOTE: reset is synchronous here, so it sits inside the clocked branch and
  // is sampled only on the rising edge like any other input.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state and walker control; the walker start is issued on the edge that
  // enters ERASE or DRAW so its first pixel is valid in that state's first cycle.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    walk_start  = 1'b0;
    walk_colour = BG_COLOUR;
    case (state)
      ST_IDLE: begin
        if (frame_tick || pending) begin
          if (skip_erase) begin
            next_state = ST_COLL;
          end else begin
            next_state = ST_ERASE;
            walk_start = 1'b1;
          end
        end
      end
      ST_ERASE:  if (walk_done) next_state = ST_COLL;
      ST_COLL:   next_state = ST_SETTLE;
      ST_SETTLE: next_state = ST_MOVE;
      ST_MOVE: begin
        next_state  = ST_DRAW;
        walk_start  = 1'b1;
        walk_colour = BALL_COLOUR;
      end
      ST_DRAW:   if (walk_done) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Registered control outputs, tick capture, position update and scoring.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      coll_enable <= 1'b0;
      pending     <= 1'b0;
      skip_erase  <= 1'b1;
      x_ball      <= X_START;
      y_ball      <= Y_START;
      score1      <= '0;
      score2      <= '0;
    end else begin
      busy        <= (next_state != ST_IDLE);
      coll_enable <= (next_state == ST_COLL);

      // IDLE always leaves when pending is set, so clearing here is exact;
      // ticks elsewhere (including the DRAW->IDLE cycle) collapse into one.
      if (state == ST_IDLE)  pending <= 1'b0;
      else if (frame_tick)   pending <= 1'b1;

      // Flags are taken at the end of SETTLE; the new position shows in MOVE.
      if (state == ST_SETTLE) begin
        if (goal_left || goal_right) begin
          x_ball     <= X_START;
          y_ball     <= Y_START;
          skip_erase <= 1'b1;
          if (goal_left  && score2 != SCORE_MAX) score2 <= score2 + 4'd1;
          if (goal_right && score1 != SCORE_MAX) score1 <= score1 + 4'd1;
        end else begin
          x_ball     <= x_step;
          y_ball     <= y_step;
          skip_erase <= 1'b0;
        end
      end
    end
  end

  box_pixel_walker u_walker (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (walk_start),
    .origin_x    (x_ball),
    .origin_y    (y_ball),
    .colour      (walk_colour),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .plot_valid  (plot_valid),
    .done        (walk_done)
  );

endmodule

// File: doc/ball_sequencer.md
# ball_sequencer

Per-frame controller for the ball datapath of the air-hockey game. On each frame tick it erases the ball at its old position, strobes the collision block with the current position to refresh the direction flags, advances the ball one pixel per axis, detects goals, and redraws the ball. It sits between the frame-rate divider, the collision block, and the VGA pixel plotter. It owns the ball position registers and both score counters.

## Interface
- FIELD_W, 100: playfield width in pixels.
- FIELD_H, 100: playfield height in pixels.
- X_INIT, 48: ball x after reset and after a goal.
- Y_INIT, 48: ball y after reset and after a goal.
- GOAL_Y0, 30: first row of the goal mouth (ball top y), inclusive.
- GOAL_Y1, 66: last row of the goal mouth (ball top y), inclusive.
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse that starts a move sequence.
- horizontal  in  1  collision flag: 1 = move +x, 0 = move −x.
- vertical  in  1  collision flag: 1 = move −y, 0 = move +y.
- coll_enable  out  1  one-cycle strobe to the collision block.
- x_ball, y_ball  out  11 each  top-left pixel of the 4×4 ball.
- plot_x, plot_y  out  11 each  pixel coordinate to plot.
- plot_colour  out  3  pixel colour.
- plot_valid  out  1  pixel request.
- plot_ready  in  1  plotter accepts the pixel.
- score1, score2  out  4 each  goal counts, 0–9, saturating.
- busy  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE → ERASE → COLL → SETTLE → MOVE → DRAW → IDLE.
- **IDLE:** wait for frame_tick or a pending tick.
  - A frame_tick seen outside IDLE sets `pending`.
  - Further ticks while `pending` is set collapse into it; there is no queue.
  - `pending` clears when IDLE leaves on it.
- **ERASE:** walk 16 pixels at (x_ball+dx, y_ball+dy), colour BG_COLOUR (3'b000).
  - offset cnt[3:0] gives dx = cnt[1:0], dy = cnt[3:2]; raster order.
  - cnt advances only when plot_valid && plot_ready.
  - Leave after cnt = 15 is accepted.
  - ERASE is skipped (IDLE → COLL) on the first sequence after reset and the first after a goal.
- **COLL:** coll_enable = 1 for exactly one cycle.
- **SETTLE:** one idle cycle; flags are sampled at the end of SETTLE.
- **MOVE:** x ± 1 and y ± 1 per the flags, each saturated to [0, FIELD_W−4] and [0, FIELD_H−4].
  - All arithmetic is 11-bit unsigned.
  - Decrement at 0 holds 0; increment at the maximum holds the maximum.
- **Goals** (checked on the post-move position):
  - x = 0 with y in [GOAL_Y0, GOAL_Y1]: score2 += 1.
  - x = FIELD_W−4 with y in [GOAL_Y0, GOAL_Y1]: score1 += 1.
  - On either goal the ball reloads X_INIT/Y_INIT and the skip-erase flag is set.
  - Scores saturate at 9.
- **DRAW:** same 16-pixel walk as ERASE, colour BALL_COLOUR (3'b111), at the new position.
- **Reset (synchronous, any state, including mid-walk):**
  - State IDLE; cnt = 0; pending = 0; skip-erase = 1.
  - x_ball = X_INIT, y_ball = Y_INIT.
  - plot_valid = 0, coll_enable = 0, score1 = score2 = 0, busy = 0.
  - plot_x/plot_y/plot_colour = 0.

## Timing
- All outputs are registered.
- frame_tick in IDLE → busy and the first ERASE plot_valid the next cycle.
- **Handshake:**
  - plot_valid, plot_x, plot_y, and plot_colour hold stable until accepted.
  - plot_valid never drops without acceptance.
  - Back-to-back pixels are allowed (one per cycle with ready held high).
- With plot_ready held high, a full sequence is 16 + 1 + 1 + 1 + 16 = 35 cycles from IDLE exit to IDLE return; it is 19 cycles when erase is skipped.
- x_ball/y_ball change only on the MOVE cycle.
  - The collision block sees the old position during COLL and SETTLE.
- frame_tick in the same cycle the FSM returns to IDLE is counted as pending and serviced the next cycle.

## Structure
- **Shared package `game_pkg`:**
  - FIELD_W, FIELD_H, and BALL_SIZE = 4.
  - BG_COLOUR and BALL_COLOUR.
  - The state enum.
  - Score width (4) and SCORE_MAX = 9.
- **Sub-module `box_pixel_walker`:**
  - Contents: the 4-bit offset counter, the valid/ready handshake, and coordinate/colour registers.
  - Inputs: start, origin, colour.
  - Output: done.
  - Instantiated once and shared by ERASE and DRAW.

## Test plan
- Reset, then frame_tick with ready = 1, flags h=1, v=0.
  - Expect no erase, coll_enable at cycle 1, 16 draw pixels at (49..52, 49..52).
  - Expect busy low 19 cycles after the tick.
- Second tick with ready toggling 1/0 each cycle.
  - Expect 16 erase pixels at the old origin with each pixel held until accepted, then 16 draws at (50, 50).
- Ball at x = 96, y = 10, h=1.
  - Expect x held at 96 by saturation and no score.
- Ball at x = 1, y = 40, h=0.
  - Expect x = 0, score2 = 1, ball reloaded to (48, 48), next sequence skips erase.
- score1 = 9, then another right goal.
  - Expect score1 to stay 9.
- Two frame_ticks during DRAW, then reset_n = 0 mid-ERASE of the following sequence.
  - Expect exactly one extra sequence queued.
  - On reset, expect plot_valid = 0 the next cycle and all outputs at their reset values.
